// File: rtl/id_ex_operand_stage_pkg.sv
// Shared encodings for the ID/EX operand stage: ALU control codes, aluop classes,
// R-type funct patterns and default widths.
package id_ex_operand_stage_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_RA_W   = 5;

  typedef enum logic [2:0] {
    ALU_ZERO = 3'b000,
    ALU_AND  = 3'b001,
    ALU_OR   = 3'b010,
    ALU_ADD  = 3'b011,
    ALU_SUB  = 3'b100,
    ALU_MUL  = 3'b101,
    ALU_PASS = 3'b110
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ALUOP_MEM    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_ITYPE  = 2'b11
  } aluop_e;

  // {funct7, funct3}
  localparam logic [9:0] FUNCT_ADD = 10'b0000000_000;
  localparam logic [9:0] FUNCT_SUB = 10'b0100000_000;
  localparam logic [9:0] FUNCT_MUL = 10'b0000001_000;
  localparam logic [9:0] FUNCT_AND = 10'b0000000_111;
  localparam logic [9:0] FUNCT_OR  = 10'b0000000_110;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Bundle of everything the ID/EX operand stage exchanges with ID, the forwarding
// sources, the hazard unit and the ALU. The stage itself is the slave.
interface id_ex_operand_stage_if
  import id_ex_operand_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RA_W   = DEF_RA_W
);
  logic              hold_i;
  logic              flush_i;
  logic              id_valid_i;
  logic [DATA_W-1:0] id_rs1_data_i;
  logic [DATA_W-1:0] id_rs2_data_i;
  logic [RA_W-1:0]   id_rs1_i;
  logic [RA_W-1:0]   id_rs2_i;
  logic [RA_W-1:0]   id_rd_i;
  logic [DATA_W-1:0] id_imm_i;
  logic              id_alusrc_i;
  logic [1:0]        id_aluop_i;
  logic [9:0]        id_funct_i;
  logic              id_regwrite_i;
  logic              id_memread_i;
  logic              id_memwrite_i;
  logic              id_memtoreg_i;
  logic              exmem_regwrite_i;
  logic [RA_W-1:0]   exmem_rd_i;
  logic [DATA_W-1:0] exmem_data_i;
  logic              memwb_regwrite_i;
  logic [RA_W-1:0]   memwb_rd_i;
  logic [DATA_W-1:0] memwb_data_i;

  logic [DATA_W-1:0] data1_o;
  logic [DATA_W-1:0] data2_o;
  logic [2:0]        alu_ctrl_o;
  logic [DATA_W-1:0] store_data_o;
  logic [RA_W-1:0]   rd_o;
  logic              valid_o;
  logic              regwrite_o;
  logic              memread_o;
  logic              memwrite_o;
  logic              memtoreg_o;
  logic              load_use_o;

  modport master (
    output hold_i, flush_i, id_valid_i, id_rs1_data_i, id_rs2_data_i,
           id_rs1_i, id_rs2_i, id_rd_i, id_imm_i, id_alusrc_i, id_aluop_i,
           id_funct_i, id_regwrite_i, id_memread_i, id_memwrite_i, id_memtoreg_i,
           exmem_regwrite_i, exmem_rd_i, exmem_data_i,
           memwb_regwrite_i, memwb_rd_i, memwb_data_i,
    input  data1_o, data2_o, alu_ctrl_o, store_data_o, rd_o, valid_o,
           regwrite_o, memread_o, memwrite_o, memtoreg_o, load_use_o
  );

  modport slave (
    input  hold_i, flush_i, id_valid_i, id_rs1_data_i, id_rs2_data_i,
           id_rs1_i, id_rs2_i, id_rd_i, id_imm_i, id_alusrc_i, id_aluop_i,
           id_funct_i, id_regwrite_i, id_memread_i, id_memwrite_i, id_memtoreg_i,
           exmem_regwrite_i, exmem_rd_i, exmem_data_i,
           memwb_regwrite_i, memwb_rd_i, memwb_data_i,
    output data1_o, data2_o, alu_ctrl_o, store_data_o, rd_o, valid_o,
           regwrite_o, memread_o, memwrite_o, memtoreg_o, load_use_o
  );
endinterface

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Single-operand forwarding select; EX/MEM beats MEM/WB and x0 never forwards.
module id_ex_operand_stage_fwd_mux
  import id_ex_operand_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RA_W   = DEF_RA_W
) (
  input  logic [RA_W-1:0]   rs,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              exmem_regwrite,
  input  logic [RA_W-1:0]   exmem_rd,
  input  logic [DATA_W-1:0] exmem_data,
  input  logic              memwb_regwrite,
  input  logic [RA_W-1:0]   memwb_rd,
  input  logic [DATA_W-1:0] memwb_data,
  output logic [DATA_W-1:0] data
);

  always_comb begin
    data = rf_data;
    if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == rs))
      data = exmem_data;
    else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == rs))
      data = memwb_data;
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU: captures ID operands/control, decodes
// the ALU control code, applies forwarding and flags load-use hazards.
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RA_W   = DEF_RA_W
) (
  input logic                  clk_i,
  input logic                  rst_i,
  id_ex_operand_stage_if.slave bus
);

  logic              valid_q, regwrite_q, memread_q, memwrite_q, memtoreg_q, alusrc_q;
  logic [1:0]        aluop_q;
  logic [9:0]        funct_q;
  logic [RA_W-1:0]   rs1_q, rs2_q, rd_q;
  logic [DATA_W-1:0] rs1_data_q, rs2_data_q, imm_q;
  logic [DATA_W-1:0] fwd_rs1, fwd_rs2;

  function automatic alu_ctrl_e alu_decode(input logic valid, input logic [1:0] aluop,
                                           input logic [9:0] funct);
    alu_ctrl_e code;
    code = ALU_ZERO;
    if (valid) begin
      case (aluop)
        ALUOP_MEM:    code = ALU_ADD;
        ALUOP_BRANCH: code = ALU_SUB;
        ALUOP_ITYPE:  code = ALU_ADD;
        default: begin
          case (funct)
            FUNCT_ADD: code = ALU_ADD;
            FUNCT_SUB: code = ALU_SUB;
            FUNCT_MUL: code = ALU_MUL;
            FUNCT_AND: code = ALU_AND;
            FUNCT_OR:  code = ALU_OR;
            default:   code = ALU_ZERO;
          endcase
        end
      endcase
    end
    return code;
  endfunction

  // Flush outranks hold so a load-use bubble still lands while IF/ID is held.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i || bus.flush_i) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      alusrc_q   <= 1'b0;
      aluop_q    <= '0;
      funct_q    <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
    end else if (!bus.hold_i) begin
      valid_q    <= bus.id_valid_i;
      regwrite_q <= bus.id_regwrite_i && bus.id_valid_i;
      memread_q  <= bus.id_memread_i  && bus.id_valid_i;
      memwrite_q <= bus.id_memwrite_i && bus.id_valid_i;
      memtoreg_q <= bus.id_memtoreg_i && bus.id_valid_i;
      alusrc_q   <= bus.id_alusrc_i;
      aluop_q    <= bus.id_aluop_i;
      funct_q    <= bus.id_funct_i;
      rs1_q      <= bus.id_rs1_i;
      rs2_q      <= bus.id_rs2_i;
      rd_q       <= bus.id_rd_i;
      rs1_data_q <= bus.id_rs1_data_i;
      rs2_data_q <= bus.id_rs2_data_i;
      imm_q      <= bus.id_imm_i;
    end
  end

  id_ex_operand_stage_fwd_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd_rs1 (
    .rs(rs1_q), .rf_data(rs1_data_q),
    .exmem_regwrite(bus.exmem_regwrite_i), .exmem_rd(bus.exmem_rd_i), .exmem_data(bus.exmem_data_i),
    .memwb_regwrite(bus.memwb_regwrite_i), .memwb_rd(bus.memwb_rd_i), .memwb_data(bus.memwb_data_i),
    .data(fwd_rs1)
  );

  id_ex_operand_stage_fwd_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd_rs2 (
    .rs(rs2_q), .rf_data(rs2_data_q),
    .exmem_regwrite(bus.exmem_regwrite_i), .exmem_rd(bus.exmem_rd_i), .exmem_data(bus.exmem_data_i),
    .memwb_regwrite(bus.memwb_regwrite_i), .memwb_rd(bus.memwb_rd_i), .memwb_data(bus.memwb_data_i),
    .data(fwd_rs2)
  );

  assign bus.data1_o      = fwd_rs1;
  assign bus.store_data_o = fwd_rs2;
  assign bus.data2_o      = alusrc_q ? imm_q : fwd_rs2;
  assign bus.alu_ctrl_o   = alu_decode(valid_q, aluop_q, funct_q);
  assign bus.rd_o         = rd_q;
  assign bus.valid_o      = valid_q;
  assign bus.regwrite_o   = regwrite_q;
  assign bus.memread_o    = memread_q;
  assign bus.memwrite_o   = memwrite_q;
  assign bus.memtoreg_o   = memtoreg_q;

  // Compares the registered load against the instruction still sitting in ID.
  assign bus.load_use_o = memread_q && (rd_q != '0) && bus.id_valid_i &&
                          ((rd_q == bus.id_rs1_i) || (rd_q == bus.id_rs2_i));

endmodule
